mips_instr_decoder: RTL and testbench

//  Main control decoder for a single-cycle/pipelined MIPS32 datapath.

---
 rtl/mips_decoder_pkg.sv | 47 ++++
 rtl/mips_ctrl_rom.sv | 74 +++++++
 rtl/mips_instr_decoder.sv | 96 +++++++++
 tb/tb_mips_instr_decoder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mips_decoder_pkg.sv
// -----------------------------------------------------------------------------
// mips_decoder_pkg
// Purpose : Shared definitions for the MIPS32 main control decoder:
//           opcode constants, ALUOp encodings, the control-word struct, and a
//           helper that checks a control word for mutually exclusive enables.
// Config  : MIPS_DECODER_JUMP_EN adds a jump field to the control word.
// -----------------------------------------------------------------------------
package mips_decoder_pkg;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp encodings handed to the ALU control stage
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Full control word produced by the lookup and held in the output register
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
`ifdef MIPS_DECODER_JUMP_EN
    logic       jump;
`endif
    logic       illegal;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_ZERO = '0;

  // A control word must never read and write memory together, nor write the
  // register file while storing to memory.
  function automatic logic ctrl_is_safe(input ctrl_word_t c);
    return !(c.mem_read && c.mem_write) && !(c.reg_write && c.mem_write);
  endfunction

endpackage

// File: rtl/mips_ctrl_rom.sv
// -----------------------------------------------------------------------------
// mips_ctrl_rom
// Purpose : Purely combinational opcode -> control-word lookup.
// Ports   : opcode [5:0] in  - instr[31:26]
//           ctrl         out - decoded control word (illegal set for
//                              unsupported opcodes, all other fields 0)
// Config  : MIPS_DECODER_JUMP_EN makes opcode 000010 (j) legal with jump=1;
//           without it, 000010 is illegal.
// -----------------------------------------------------------------------------
module mips_ctrl_rom
  import mips_decoder_pkg::*;
(
  input  logic [5:0]  opcode,
  output ctrl_word_t  ctrl
);

  ctrl_word_t raw;

  always_comb begin
    // Start from an all-zero word so that every "don't care" control is a
    // hard 0 rather than X.
    raw = CTRL_ZERO;
    case (opcode)
      OP_RTYPE: begin
        raw.reg_dst   = 1'b1;
        raw.reg_write = 1'b1;
        raw.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        raw.alu_src    = 1'b1;
        raw.mem_to_reg = 1'b1;
        raw.reg_write  = 1'b1;
        raw.mem_read   = 1'b1;
        raw.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        raw.alu_src   = 1'b1;
        raw.mem_write = 1'b1;
        raw.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        raw.branch = 1'b1;
        raw.alu_op = ALUOP_SUB;
      end
      OP_ADDI: begin
        raw.alu_src   = 1'b1;
        raw.reg_write = 1'b1;
        raw.alu_op    = ALUOP_ADD;
      end
      OP_J: begin
`ifdef MIPS_DECODER_JUMP_EN
        raw.jump = 1'b1;
`else
        raw.illegal = 1'b1;
`endif
      end
      default: begin
        raw.illegal = 1'b1;
      end
    endcase
  end

  // Last line of defence: a word with conflicting enables is replaced by the
  // safe illegal word instead of reaching the datapath.
  always_comb begin
    if (ctrl_is_safe(raw)) begin
      ctrl = raw;
    end else begin
      ctrl         = CTRL_ZERO;
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/mips_instr_decoder.sv
// -----------------------------------------------------------------------------
// mips_instr_decoder
// Purpose : MIPS32 main control decoder. Decodes instr[31:26] into datapath
//           controls, registered with one cycle of latency. Bubbles
//           (in_valid=0) yield an all-zero output word with out_valid=0.
// Ports   : clk, rst (async, active-high)
//           in_valid, instr[INSTR_W-1:0]            - instruction input
//           out_valid                                - controls valid
//           RegDst, ALUSrc, MemtoReg, RegWrite,
//           MemRead, MemWrite, Branch, ALUOp[1:0]    - datapath controls
//           illegal                                  - unsupported opcode
//           Jump (only with MIPS_DECODER_JUMP_EN)    - unconditional jump
// Config  : MIPS_DECODER_JUMP_EN adds the Jump port and decodes opcode j.
// -----------------------------------------------------------------------------
module mips_instr_decoder
  import mips_decoder_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               out_valid,
  output logic               RegDst,
  output logic               ALUSrc,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               Branch,
  output logic [ALUOP_W-1:0] ALUOp,
`ifdef MIPS_DECODER_JUMP_EN
  output logic               Jump,
`endif
  output logic               illegal
);

  // Only the 32-bit instruction / 2-bit ALUOp configuration is meaningful.
  generate
    if (INSTR_W != 32) begin : g_bad_instr_w
      $error("mips_instr_decoder: INSTR_W must be 32");
    end
    if (ALUOP_W != 2) begin : g_bad_aluop_w
      $error("mips_instr_decoder: ALUOP_W must be 2");
    end
  endgenerate

  // Everything below the opcode (registers, immediate, funct) is ignored here;
  // ALU control decodes funct separately.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:0];

  ctrl_word_t rom_ctrl;

  mips_ctrl_rom u_ctrl_rom (
    .opcode (instr[31:26]),
    .ctrl   (rom_ctrl)
  );

  logic       valid_d, valid_q;
  ctrl_word_t ctrl_d,  ctrl_q;

  always_comb begin
    valid_d = in_valid;
    // A bubble carries no side effects: every control, including illegal,
    // is cleared.
    ctrl_d  = in_valid ? rom_ctrl : CTRL_ZERO;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_ZERO;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_valid = valid_q;
  assign RegDst    = ctrl_q.reg_dst;
  assign ALUSrc    = ctrl_q.alu_src;
  assign MemtoReg  = ctrl_q.mem_to_reg;
  assign RegWrite  = ctrl_q.reg_write;
  assign MemRead   = ctrl_q.mem_read;
  assign MemWrite  = ctrl_q.mem_write;
  assign Branch    = ctrl_q.branch;
  assign ALUOp     = ctrl_q.alu_op;
  assign illegal   = ctrl_q.illegal;
`ifdef MIPS_DECODER_JUMP_EN
  assign Jump      = ctrl_q.jump;
`endif

endmodule

// File: tb/tb_mips_instr_decoder.sv
// -----------------------------------------------------------------------------
// tb_mips_instr_decoder
// Directed-vector bench for mips_instr_decoder. Observed outputs are packed as
// {out_valid, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
//  ALUOp[1:0], illegal, Jump}; Jump reads as 0 when MIPS_DECODER_JUMP_EN is
// not defined.
// -----------------------------------------------------------------------------
module tb_mips_instr_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic        out_valid, RegDst, ALUSrc, MemtoReg, RegWrite;
  logic        MemRead, MemWrite, Branch, illegal;
  logic [1:0]  ALUOp;
  logic        jump_obs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_instr_decoder #(.INSTR_W(32), .ALUOP_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .instr     (instr),
    .out_valid (out_valid),
    .RegDst    (RegDst),
    .ALUSrc    (ALUSrc),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Branch    (Branch),
    .ALUOp     (ALUOp),
`ifdef MIPS_DECODER_JUMP_EN
    .Jump      (jump_obs),
`endif
    .illegal   (illegal)
  );

`ifndef MIPS_DECODER_JUMP_EN
  assign jump_obs = 1'b0;
`endif

  // Expected words: v RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp ill J
  localparam logic [11:0] E_ZERO = 12'b0_0000000_00_00;
  localparam logic [11:0] E_ADD  = 12'b1_1001000_10_00;
  localparam logic [11:0] E_LW   = 12'b1_0111100_00_00;
  localparam logic [11:0] E_SW   = 12'b1_0100010_00_00;
  localparam logic [11:0] E_BEQ  = 12'b1_0000001_01_00;
  localparam logic [11:0] E_ADDI = 12'b1_0101000_00_00;
  localparam logic [11:0] E_ILL  = 12'b1_0000000_00_10;
`ifdef MIPS_DECODER_JUMP_EN
  localparam logic [11:0] E_J    = 12'b1_0000000_00_01;
`else
  localparam logic [11:0] E_J    = 12'b1_0000000_00_10;
`endif

  function automatic logic [11:0] obs();
    return {out_valid, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
            Branch, ALUOp, illegal, jump_obs};
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  // One transaction: drive on the falling edge, sample 1 time unit after the
  // capturing rising edge, so the result belongs to this instruction.
  task automatic step(input string tag, input logic v, input logic [31:0] w,
                      input logic [11:0] exp);
    logic [11:0] got;
    @(negedge clk);
    in_valid = v;
    instr    = w;
    @(posedge clk);
    #1;
    got = obs();
    $display("txn %-10s in_valid=%0b instr=%08h -> out=%b", tag, v, w, got);
    check(tag, got, exp);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    instr    = 32'h0;

    // Reset held: inputs toggle, outputs must stay zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      instr    = (i % 2 == 0) ? 32'h8D280004 : 32'h014B4820;
      @(posedge clk);
      #1;
      $display("txn rst_hold   in_valid=%0b instr=%08h -> out=%b", in_valid, instr, obs());
      check("rst_hold", obs(), E_ZERO);
    end

    // Release reset with no valid input: still zero.
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    instr    = 32'h014B4820;
    @(posedge clk);
    #1;
    $display("txn rst_rel    in_valid=0 instr=%08h -> out=%b", instr, obs());
    check("rst_release", obs(), E_ZERO);

    // Back-to-back valid stream.
    step("add",    1'b1, 32'h014B4820, E_ADD);
    step("lw",     1'b1, 32'h8D280004, E_LW);
    step("sw",     1'b1, 32'hAD280004, E_SW);
    step("beq",    1'b1, 32'h112A0002, E_BEQ);
    step("addi",   1'b1, 32'h21290005, E_ADDI);
    step("ill_3f", 1'b1, 32'hFC000000, E_ILL);
    step("rtype0", 1'b1, 32'h00000000, E_ADD);
    step("ill_01", 1'b1, 32'h04000000, E_ILL);
    step("jump",   1'b1, 32'h08000010, E_J);
    step("beq_b",  1'b1, 32'h13FFFFFF, E_BEQ);

    // lw, bubble, lw
    step("lw_a",   1'b1, 32'h8D280004, E_LW);
    step("bubble", 1'b0, 32'hAD280004, E_ZERO);
    step("lw_b",   1'b1, 32'h8D280004, E_LW);

    // Asynchronous reset mid-cycle clears outputs before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    $display("txn async_rst  -> out=%b", obs());
    check("async_rst", obs(), E_ZERO);
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 1'b1, 32'hAD280004, E_SW);
    step("post_ill", 1'b1, 32'h7C000000, E_ILL);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the bench always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
